// File: rtl/cbd_polyvec_streamer.sv
// Captures a CBD-sampled polyvec in one cycle and streams it as canonical mod-q
// 12-bit coefficient beats over valid/ready, so the sampler can refill while this drains.
module cbd_polyvec_streamer #(
    parameter int ML_KEM_K = 3,
    parameter int LANES    = 8,
    parameter int Q        = 3329
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    load_i,
    input  logic [2*ML_KEM_K*256*8-1:0]             polyvec_i,
    output logic                                    ready_o,
    output logic                                    valid_o,
    input  logic                                    ready_i,
    output logic [LANES*12-1:0]                     data_o,
    output logic [$clog2(2*ML_KEM_K)-1:0]           poly_idx_o,
    output logic [$clog2(256/LANES)-1:0]            beat_idx_o,
    output logic                                    last_poly_o,
    output logic                                    last_o,
    output logic                                    done_o
);
    localparam int NP = 2 * ML_KEM_K;
    localparam int NB = 256 / LANES;
    localparam int PW = $clog2(NP);
    localparam int BW = $clog2(NB);
    localparam int VW = NP * 256 * 8;

    // Handshake: a beat transfers on a rising clk edge where valid_o & ready_i;
    // a load is taken on an edge where load_i & ready_o. valid_o/ready_o are never both high.
    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [VW-1:0]     buf_q;
    logic [PW-1:0]     poly_q, poly_nxt;
    logic [BW-1:0]     beat_q, beat_nxt;
    logic [LANES*12-1:0] data_q, data_nxt;
    logic              done_q;
    logic              hs, final_beat, load_ok;

    function automatic logic [11:0] to_mod_q(input logic [7:0] s);
        logic [12:0] w;
        w = {{5{s[7]}}, s};
        if (s[7]) w = w + 13'(Q);
        return w[11:0];
    endfunction

    function automatic logic [LANES*12-1:0] beat_lanes(input logic [VW-1:0] src,
                                                       input logic [PW-1:0] p,
                                                       input logic [BW-1:0] b);
        logic [LANES*12-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++)
            r[l*12 +: 12] = to_mod_q(src[(int'(p) * 256 + int'(b) * LANES + l) * 8 +: 8]);
        return r;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_i)     state_nxt = STREAM;
            STREAM:  if (final_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_o     = (state == IDLE);
        valid_o     = (state == STREAM);
        last_poly_o = valid_o && (beat_q == BW'(NB - 1));
        last_o      = last_poly_o && (poly_q == PW'(NP - 1));
    end

    assign hs         = valid_o & ready_i;
    assign final_beat = hs & last_o;
    assign load_ok    = ready_o & load_i;

    // The first beat is converted straight from polyvec_i since the buffer fills on the same edge.
    always_comb begin
        poly_nxt = poly_q;
        beat_nxt = beat_q;
        data_nxt = data_q;
        if (load_ok) begin
            poly_nxt = '0;
            beat_nxt = '0;
            data_nxt = beat_lanes(polyvec_i, '0, '0);
        end else if (hs) begin
            if (final_beat) begin
                poly_nxt = '0;
                beat_nxt = '0;
                data_nxt = '0;
            end else begin
                if (beat_q == BW'(NB - 1)) begin
                    beat_nxt = '0;
                    poly_nxt = poly_q + PW'(1);
                end else begin
                    beat_nxt = beat_q + BW'(1);
                end
                data_nxt = beat_lanes(buf_q, poly_nxt, beat_nxt);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_q  <= '0;
            poly_q <= '0;
            beat_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            if (load_ok) buf_q <= polyvec_i;
            poly_q <= poly_nxt;
            beat_q <= beat_nxt;
            data_q <= data_nxt;
            done_q <= final_beat;
        end
    end

    assign data_o     = data_q;
    assign poly_idx_o = poly_q;
    assign beat_idx_o = beat_q;
    assign done_o     = done_q;
endmodule

// File: tb/tb_cbd_polyvec_streamer.sv
// Scoreboard bench for cbd_polyvec_streamer: directed polyvecs, expected beats queued at load.
module tb_cbd_polyvec_streamer;
    localparam int K  = 3;
    localparam int L  = 8;
    localparam int VW = 2 * K * 256 * 8;
    localparam int W  = 1 + 1 + 3 + 5 + L * 12;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            load_i;
    logic [VW-1:0]   pv;
    logic            ready_o, valid_o, ready_i;
    logic [L*12-1:0] data_o;
    logic [2:0]      poly_idx_o;
    logic [4:0]      beat_idx_o;
    logic            last_poly_o, last_o, done_o;

    cbd_polyvec_streamer #(.ML_KEM_K(K), .LANES(L), .Q(3329)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .load_i(load_i), .polyvec_i(pv),
        .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .poly_idx_o(poly_idx_o), .beat_idx_o(beat_idx_o), .last_poly_o(last_poly_o),
        .last_o(last_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int load_cyc = 0;
    int done_cyc = 0;
    int hs_count = 0;
    bit done_seen = 0;
    bit lat_chk = 0;
    bit exp_done_next = 0;
    bit stall_pend = 0;
    bit bp_mode = 0;
    logic [W-1:0] snap;
    logic [W-1:0] exp_q[$];
    int exp_c[1536];

    int tbl7[7] = '{3326, 3327, 3328, 0, 1, 2, 3};
    int tbl5[5] = '{3327, 3328, 0, 1, 2};
    int ext_v[4] = '{-128, 127, -1, 0};
    int ext_e[4] = '{3201, 127, 3328, 0};

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1 ready_i = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic build(input int pat);
        for (int i = 0; i < 1536; i++) begin
            int v, e;
            if (pat == 0)      begin v = (i % 7) - 3; e = tbl7[i % 7]; end
            else if (pat == 1) begin v = (i % 5) - 2; e = tbl5[i % 5]; end
            else               begin v = ext_v[i % 4]; e = ext_e[i % 4]; end
            pv[i*8 +: 8] = 8'(v);
            exp_c[i] = e;
        end
    endtask

    task automatic push_all();
        for (int p = 0; p < 6; p++)
            for (int b = 0; b < 32; b++) begin
                logic [L*12-1:0] d;
                logic lp, la;
                for (int l = 0; l < L; l++) d[l*12 +: 12] = 12'(exp_c[p*256 + b*L + l]);
                lp = (b == 31);
                la = lp && (p == 5);
                exp_q.push_back({la, lp, 3'(p), 5'(b), d});
            end
    endtask

    task automatic do_load();
        load_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL load_ready got %b want 1", ready_o); end
        load_cyc = cyc;
        lat_chk = 1;
        done_seen = 0;
        hs_count = 0;
        push_all();
        @(posedge clk_i);
        #1 load_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_seen; i++) @(posedge clk_i);
        if (!done_seen) begin
            errors++;
            $display("FAIL done_timeout got no done_o within %0d cycles", budget);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 2000 && hs_count < n; i++) @(posedge clk_i);
        if (hs_count < n) begin errors++; $display("FAIL beat_timeout got %0d want %0d", hs_count, n); end
    endtask

    always @(negedge clk_i) begin
        logic [W-1:0] obs, exp;
        if (rst_i) begin
            stall_pend = 0;
            exp_done_next = 0;
        end else begin
            obs = {last_o, last_poly_o, poly_idx_o, beat_idx_o, data_o};
            checks++;
            if (done_o !== exp_done_next) begin
                errors++;
                $display("FAIL done_pulse got %b want %b at cyc %0d", done_o, exp_done_next, cyc);
            end
            if (done_o) begin done_seen = 1; done_cyc = cyc; end
            if (exp_done_next) begin
                checks++;
                if (ready_o !== 1'b1) begin errors++; $display("FAIL ready_at_done got %b want 1", ready_o); end
                exp_done_next = 0;
            end
            if (lat_chk && cyc == load_cyc + 1) begin
                checks++;
                if (valid_o !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", valid_o); end
                lat_chk = 0;
            end
            if (stall_pend) begin
                checks++;
                if (valid_o !== 1'b1 || obs !== snap) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b %h want v=1 %h", valid_o, obs, snap);
                end
            end
            stall_pend = valid_o && !ready_i;
            snap = obs;
            if (valid_o && ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat got %h want no beat", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL beat got %h want %h", obs, exp);
                    end
                    if (exp[W-1]) exp_done_next = 1;
                end
                hs_count++;
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        load_i = 1'b0;
        pv = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            checks++;
            if (ready_o !== 1'b1 || valid_o !== 1'b0 || data_o !== '0 || poly_idx_o !== 3'd0 ||
                beat_idx_o !== 5'd0 || last_o !== 1'b0 || last_poly_o !== 1'b0) begin
                errors++;
                $display("FAIL idle got r=%b v=%b p=%0d b=%0d want r=1 v=0 p=0 b=0",
                         ready_o, valid_o, poly_idx_o, beat_idx_o);
            end
        end
        @(posedge clk_i);
        #1;

        // Full-throughput stream
        build(0);
        do_load();
        wait_done(400);
        checks++;
        if (done_cyc - load_cyc != 193) begin
            errors++;
            $display("FAIL done_latency got %0d want 193", done_cyc - load_cyc);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL leftover got %0d want 0", exp_q.size()); end

        // Backpressure
        bp_mode = 1;
        build(0);
        do_load();
        wait_done(2000);
        bp_mode = 0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_leftover got %0d want 0", exp_q.size()); end

        // Load during stream is ignored; reload afterwards takes effect
        build(0);
        do_load();
        wait_beats(40);
        @(posedge clk_i);
        #1;
        build(1);
        load_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", ready_o); end
        @(posedge clk_i);
        #1 load_i = 1'b0;
        wait_done(400);
        do_load();
        wait_done(400);

        // Reset mid-stream
        build(0);
        do_load();
        wait_beats(100);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || poly_idx_o !== 3'd0 || beat_idx_o !== 5'd0 ||
            data_o !== '0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got v=%b r=%b p=%0d b=%0d want v=0 r=1 p=0 b=0",
                     valid_o, ready_o, poly_idx_o, beat_idx_o);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Extreme coefficients after reset restart
        build(2);
        do_load();
        wait_done(400);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL final_leftover got %0d want 0", exp_q.size()); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
